// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire NRZ bitstream into 24-bit pixels.
//
// The input is synchronized (2 FF) and edge-detected (1 FF). A 4-state FSM
// (SYNC, IDLE, HIGH, LOW) measures high times to decode bits. It measures low
// times to detect the frame latch.
//
// Ports:
//   clock, reset     core clock, synchronous active-high reset
//   i_din            asynchronous serial data line
//   o_pixel          last decoded pixel {red, green, blue}; held between strobes
//   o_pixel_valid    one-cycle strobe; o_pixel / o_led_index valid
//   o_led_index      index of the strobed pixel within its frame
//   o_frame_done     one-cycle strobe at latch detection
//   o_pixel_count    pixels accepted in the completed frame (with o_frame_done)
//   o_error          one-cycle protocol error strobe
//   o_err_code       1 short high, 2 long high, 3 partial word at latch
//   o_overflow       sticky: pixel seen beyond MAX_LEDS; cleared at frame_done
//   o_busy           FSM in HIGH or LOW

package ws2812_pkg;
    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } color_t;
endpackage

module ws2812_rx #(
    parameter int CLK_FREQ     = 20_000_000,
    // Timing defaults scale from the clock: 0.6 us, 0.15 us, 1.5 us, 50 us.
    parameter int BIT_THRESH   = CLK_FREQ * 6 / 10_000_000,
    parameter int MIN_HIGH     = CLK_FREQ * 15 / 100_000_000,
    parameter int MAX_HIGH     = CLK_FREQ * 15 / 10_000_000,
    parameter int LATCH_CYCLES = CLK_FREQ / 20_000,
    parameter int MAX_LEDS     = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_din,
    output ws2812_pkg::color_t o_pixel,
    output logic               o_pixel_valid,
    output logic [8:0]         o_led_index,
    output logic               o_frame_done,
    output logic [8:0]         o_pixel_count,
    output logic               o_error,
    output logic [1:0]         o_err_code,
    output logic               o_overflow,
    output logic               o_busy
);
    localparam logic [5:0]  BIT_THRESH_W = 6'(BIT_THRESH);
    localparam logic [5:0]  MIN_HIGH_W   = 6'(MIN_HIGH);
    localparam logic [5:0]  MAX_HIGH_W   = 6'(MAX_HIGH);
    localparam logic [10:0] LATCH_W      = 11'(LATCH_CYCLES);
    localparam logic [8:0]  MAX_LEDS_W   = 9'(MAX_LEDS);

    typedef enum logic [1:0] {S_SYNC, S_IDLE, S_HIGH, S_LOW} state_t;

    logic din_meta_q, din_sync_q, din_prev_q;
    logic rise, fall;

    state_t             state_q, state_d;
    logic [5:0]         hi_cnt_q, hi_cnt_d;
    logic [10:0]        lo_cnt_q, lo_cnt_d;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [22:0]        shift_q, shift_d;
    logic [8:0]         led_idx_q, led_idx_d;
    ws2812_pkg::color_t pixel_q, pixel_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic [8:0]         led_index_q, led_index_d;
    logic               frame_done_q, frame_done_d;
    logic [8:0]         pixel_count_q, pixel_count_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               overflow_q, overflow_d;

    logic [5:0]  hi_inc;
    logic [10:0] lo_inc;
    logic        bit_val;
    logic [23:0] word;

    assign rise    = din_sync_q & ~din_prev_q;
    assign fall    = ~din_sync_q & din_prev_q;
    assign hi_inc  = (hi_cnt_q == '1) ? hi_cnt_q : hi_cnt_q + 6'd1;
    assign lo_inc  = (lo_cnt_q == '1) ? lo_cnt_q : lo_cnt_q + 11'd1;
    assign bit_val = (hi_cnt_q >= BIT_THRESH_W);
    // Wire order is G, R, B, MSB first, so the finished word is {G, R, B}.
    assign word    = {shift_q, bit_val};

    always_comb begin
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        led_idx_d     = led_idx_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        led_index_d   = led_index_q;
        frame_done_d  = 1'b0;
        pixel_count_d = pixel_count_q;
        error_d       = 1'b0;
        err_code_d    = err_code_q;
        overflow_d    = overflow_q;

        case (state_q)
            // Wait for a full latch period of quiet line before trusting edges.
            S_SYNC: begin
                if (din_sync_q) begin
                    lo_cnt_d = '0;
                end else if (lo_cnt_q >= LATCH_W) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    led_idx_d = '0;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            S_IDLE: begin
                if (rise) begin
                    state_d  = S_HIGH;
                    hi_cnt_d = 6'd1;
                end
            end
            S_HIGH: begin
                if (hi_cnt_q >= MAX_HIGH_W) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd2;
                    bit_cnt_d  = '0;
                    lo_cnt_d   = '0;
                    state_d    = S_SYNC;
                end else if (fall) begin
                    if (hi_cnt_q < MIN_HIGH_W) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                        bit_cnt_d  = '0;
                        lo_cnt_d   = '0;
                        state_d    = S_SYNC;
                    end else begin
                        shift_d  = word[22:0];
                        lo_cnt_d = 11'd1;
                        state_d  = S_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = '0;
                            if (led_idx_q < MAX_LEDS_W) begin
                                pixel_valid_d = 1'b1;
                                pixel_d.red   = word[15:8];
                                pixel_d.green = word[23:16];
                                pixel_d.blue  = word[7:0];
                                led_index_d   = led_idx_q;
                                led_idx_d     = led_idx_q + 9'd1;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end else begin
                    hi_cnt_d = hi_inc;
                end
            end
            S_LOW: begin
                if (rise) begin
                    state_d  = S_HIGH;
                    hi_cnt_d = 6'd1;
                end else if (lo_cnt_q >= LATCH_W) begin
                    if (bit_cnt_q != '0) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end
                    if (led_idx_q != '0) begin
                        frame_done_d  = 1'b1;
                        pixel_count_d = (led_idx_q > MAX_LEDS_W) ? MAX_LEDS_W : led_idx_q;
                        overflow_d    = 1'b0;
                    end
                    bit_cnt_d = '0;
                    led_idx_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    lo_cnt_d = lo_inc;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            din_meta_q    <= 1'b0;
            din_sync_q    <= 1'b0;
            din_prev_q    <= 1'b0;
            state_q       <= S_SYNC;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            led_idx_q     <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            led_index_q   <= '0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            error_q       <= 1'b0;
            err_code_q    <= '0;
            overflow_q    <= 1'b0;
        end else begin
            din_meta_q    <= i_din;
            din_sync_q    <= din_meta_q;
            din_prev_q    <= din_sync_q;
            state_q       <= state_d;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            led_idx_q     <= led_idx_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            led_index_q   <= led_index_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            error_q       <= error_d;
            err_code_q    <= err_code_d;
            overflow_q    <= overflow_d;
        end
    end

    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_led_index   = led_index_q;
    assign o_frame_done  = frame_done_q;
    assign o_pixel_count = pixel_count_q;
    assign o_error       = error_q;
    assign o_err_code    = err_code_q;
    assign o_overflow    = overflow_q;
    assign o_busy        = (state_q == S_HIGH) || (state_q == S_LOW);
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: directed checks for ws2812_rx. A passive monitor logs strobes.
// The main sequence drives the line and compares the logs with hand-computed values.
module tb_ws2812_rx;
    logic               clock = 1'b0;
    logic               reset;
    logic               i_din;
    ws2812_pkg::color_t o_pixel;
    logic               o_pixel_valid;
    logic [8:0]         o_led_index;
    logic               o_frame_done;
    logic [8:0]         o_pixel_count;
    logic               o_error;
    logic [1:0]         o_err_code;
    logic               o_overflow;
    logic               o_busy;

    ws2812_rx dut (
        .clock(clock), .reset(reset), .i_din(i_din),
        .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid), .o_led_index(o_led_index),
        .o_frame_done(o_frame_done), .o_pixel_count(o_pixel_count),
        .o_error(o_error), .o_err_code(o_err_code),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #25 clock = ~clock;

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    // Strobe log, written only here.
    int         pix_total = 0, frame_total = 0, err_total = 0, busy_total = 0;
    logic [23:0] last_pixel;
    logic [8:0]  last_index, last_count;
    logic [1:0]  last_code;
    int          last_frame_cycle;
    logic [8:0]  idx_log [0:1023];

    always @(negedge clock) begin
        if (o_busy) busy_total++;
        if (o_pixel_valid) begin
            if (pix_total < 1024) idx_log[pix_total] = o_led_index;
            last_pixel = o_pixel;
            last_index = o_led_index;
            pix_total++;
        end
        if (o_frame_done) begin
            frame_total++;
            last_count = o_pixel_count;
            last_frame_cycle = cycle;
        end
        if (o_error) begin
            err_total++;
            last_code = o_err_code;
        end
    end

    int vectors = 0, miscompares = 0;
    int last_fall;
    int p0, f0, e0, b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        p0 = pix_total; f0 = frame_total; e0 = err_total; b0 = busy_total;
    endtask

    // All drive tasks start and end on a negedge.
    task automatic send_bit(input int hi, input int lo);
        i_din = 1'b1;
        repeat (hi) @(negedge clock);
        i_din = 1'b0;
        last_fall = cycle;
        repeat (lo) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi1, input int hi0, input int per);
        for (int i = 7; i >= 0; i--) begin
            if (b[i]) send_bit(hi1, per - hi1);
            else      send_bit(hi0, per - hi0);
        end
    endtask

    task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                              input int hi1, input int hi0, input int per);
        send_byte(g, hi1, hi0, per);
        send_byte(r, hi1, hi0, per);
        send_byte(b, hi1, hi0, per);
    endtask

    task automatic idle_low(input int n);
        i_din = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        i_din = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_pixel",  32'(o_pixel), 32'h0);
        check("rst_valid",  32'(o_pixel_valid), 32'h0);
        check("rst_frame",  32'(o_frame_done), 32'h0);
        check("rst_count",  32'(o_pixel_count), 32'h0);
        check("rst_err",    32'({o_error, o_err_code}), 32'h0);
        check("rst_ovf",    32'(o_overflow), 32'h0);
        check("rst_busy",   32'(o_busy), 32'h0);

        // Sync: a high at 500 cycles restarts the count, so a pixel sent 600
        // cycles later is still ignored.
        snap();
        idle_low(500);
        send_bit(5, 600);
        send_pixel(8'h12, 8'h34, 8'h56, 16, 8, 25);
        idle_low(1100);
        check("sync_pix",   32'(pix_total - p0), 32'd0);
        check("sync_busy",  32'(busy_total - b0), 32'd0);
        check("sync_frame", 32'(frame_total - f0), 32'd0);
        check("sync_err",   32'(err_total - e0), 32'd0);

        // Basic pixel + frame latch
        snap();
        send_pixel(8'h12, 8'h34, 8'h56, 16, 8, 25);
        idle_low(1100);
        check("px_cnt",     32'(pix_total - p0), 32'd1);
        check("px_value",   32'(last_pixel), 32'h341256);
        check("px_index",   32'(last_index), 32'd0);
        check("fr_cnt",     32'(frame_total - f0), 32'd1);
        check("fr_count",   32'(last_count), 32'd1);
        check("fr_latency", 32'(last_frame_cycle - last_fall), 32'd1003);
        check("px_busy",    32'((busy_total - b0) > 0), 32'd1);
        check("px_idle",    32'(o_busy), 32'd0);
        check("px_err",     32'(err_total - e0), 32'd0);

        // High-time boundaries: 11 -> 0, 12 -> 1, 29 -> 1, 3 -> 0
        snap();
        send_bit(11, 14);
        send_bit(12, 13);
        send_bit(29, 6);
        send_bit(3, 22);
        for (int i = 0; i < 20; i++) send_bit(8, 17);
        idle_low(1100);
        check("bnd_cnt",    32'(pix_total - p0), 32'd1);
        check("bnd_value",  32'(last_pixel), 32'h006000);
        check("bnd_err",    32'(err_total - e0), 32'd0);

        // Overflow: 258 pixels, only 256 accepted
        snap();
        for (int i = 0; i < 256; i++) send_pixel(8'h00, 8'h00, 8'h00, 12, 3, 5);
        idle_low(5);
        check("ovf_before", 32'(o_overflow), 32'd0);
        send_pixel(8'h00, 8'h00, 8'h00, 12, 3, 5);
        idle_low(5);
        check("ovf_set",    32'(o_overflow), 32'd1);
        send_pixel(8'h00, 8'h00, 8'h00, 12, 3, 5);
        idle_low(1100);
        check("ovf_pix",    32'(pix_total - p0), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (idx_log[p0 + i] !== 9'(i)) bad++;
        check("ovf_idx",    32'(bad), 32'd0);
        check("ovf_frame",  32'(frame_total - f0), 32'd1);
        check("ovf_count",  32'(last_count), 32'd256);
        check("ovf_clear",  32'(o_overflow), 32'd0);

        // Short high mid-word -> code 1, then nothing until resync + new frame
        snap();
        for (int i = 0; i < 5; i++) send_bit(16, 9);
        send_bit(2, 23);
        check("short_err",  32'(err_total - e0), 32'd1);
        check("short_code", 32'(last_code), 32'd1);
        send_pixel(8'h12, 8'h34, 8'h56, 16, 8, 25);
        idle_low(1100);
        check("short_pix",  32'(pix_total - p0), 32'd0);
        check("short_fr",   32'(frame_total - f0), 32'd0);
        snap();
        send_pixel(8'hA5, 8'h5A, 8'hFF, 16, 8, 25);
        idle_low(1100);
        check("recov_cnt",  32'(pix_total - p0), 32'd1);
        check("recov_val",  32'(last_pixel), 32'h5AA5FF);
        check("recov_idx",  32'(last_index), 32'd0);
        check("recov_fr",   32'(last_count), 32'd1);

        // Partial word at latch -> code 3, no frame_done
        snap();
        send_byte(8'hAB, 16, 8, 25);
        for (int i = 0; i < 4; i++) send_bit(16, 9);
        idle_low(1100);
        check("part_err",   32'(err_total - e0), 32'd1);
        check("part_code",  32'(last_code), 32'd3);
        check("part_fr",    32'(frame_total - f0), 32'd0);
        check("part_pix",   32'(pix_total - p0), 32'd0);

        // Long high -> code 2
        snap();
        send_bit(40, 10);
        idle_low(1100);
        check("long_err",   32'(err_total - e0), 32'd1);
        check("long_code",  32'(last_code), 32'd2);
        check("long_pix",   32'(pix_total - p0), 32'd0);

        // Reset after 10 bits: no strobes, clean resync
        snap();
        for (int i = 0; i < 10; i++) send_bit(16, 9);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("mrst_busy",  32'(o_busy), 32'd0);
        check("mrst_pixel", 32'(o_pixel), 32'h0);
        check("mrst_count", 32'(o_pixel_count), 32'd0);
        check("mrst_none",  32'((pix_total - p0) + (frame_total - f0) + (err_total - e0)), 32'd0);
        idle_low(1100);
        snap();
        send_pixel(8'h00, 8'hFF, 8'h00, 16, 8, 25);
        idle_low(1100);
        check("mrst_pix",   32'(pix_total - p0), 32'd1);
        check("mrst_val",   32'(last_pixel), 32'hFF0000);
        check("mrst_idx",   32'(last_index), 32'd0);
        check("mrst_fr",    32'(last_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
